// File: rtl/shift_issue_stage_pkg.sv
// Shared definitions for the shift issue stage.
//   - Opcode encodings carried on IN_OP.
//   - Decoded {LEFT, LOG} pairs that drive the ShiftLR control inputs.
//   - Decode result bundle passed from shift_op_decode to the top level.
package shift_issue_stage_pkg;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

    // {LEFT, LOG} for each opcode.
    localparam logic [1:0] DEC_SLL = 2'b11;
    localparam logic [1:0] DEC_SRL = 2'b01;
    localparam logic [1:0] DEC_SRA = 2'b00;
    // Illegal ops look like a logical right shift by zero, so the shifter sees quiet inputs.
    localparam logic [1:0] DEC_ILL = 2'b01;

    typedef struct packed {
        logic       left;
        logic       log;
        logic [4:0] amt;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/shift_issue_stage_decode.sv
// shift_op_decode: combinational opcode and shift-amount decode.
// Ports:
//   op      in  2  shift opcode (SLL/SRL/SRA/illegal)
//   use_imm in  1  1 selects imm, 0 selects b_lo
//   imm     in  5  immediate shift amount
//   b_lo    in  5  low bits of the register shift amount
//   dec     out    {left, log, amt, illegal}
module shift_op_decode
    import shift_issue_stage_pkg::*;
(
    input  logic [1:0] op,
    input  logic       use_imm,
    input  logic [4:0] imm,
    input  logic [4:0] b_lo,
    output dec_t       dec
);

    always_comb begin
        dec         = '0;
        dec.amt     = use_imm ? imm : b_lo;
        dec.illegal = 1'b0;
        unique case (op)
            OP_SLL: {dec.left, dec.log} = DEC_SLL;
            OP_SRL: {dec.left, dec.log} = DEC_SRL;
            OP_SRA: {dec.left, dec.log} = DEC_SRA;
            default: begin
                {dec.left, dec.log} = DEC_ILL;
                dec.amt             = 5'd0;
                dec.illegal         = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/shift_issue_stage.sv
// shift_issue_stage: two-stage pipeline wrapper around an external
// combinational 32-bit shifter (ShiftLR).
//   Stage 1 registers the decoded op and drives the shifter inputs SH_*.
//   Stage 2 captures the shifter output SH_Z into the result register.
// Ports:
//   CLK, RESET                     clock, synchronous active-high reset
//   IN_VALID/IN_READY              upstream handshake
//   IN_OP, IN_A, IN_B, IN_IMM,
//   IN_USE_IMM, IN_TAG             op fields
//   SH_X, SH_S, SH_LEFT, SH_LOG    to shifter; SH_Z from shifter
//   OUT_VALID/OUT_READY            downstream handshake
//   OUT_Z, OUT_TAG, OUT_ZERO,
//   OUT_ILLEGAL                    registered result
//   OP_COUNT                       saturating count of completed results
module shift_issue_stage
    import shift_issue_stage_pkg::*;
#(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [1:0]       IN_OP,
    input  logic [31:0]      IN_A,
    input  logic [31:0]      IN_B,
    input  logic [4:0]       IN_IMM,
    input  logic             IN_USE_IMM,
    input  logic [TAG_W-1:0] IN_TAG,
    output logic [31:0]      SH_X,
    output logic [4:0]       SH_S,
    output logic             SH_LEFT,
    output logic             SH_LOG,
    input  logic [31:0]      SH_Z,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [31:0]      OUT_Z,
    output logic [TAG_W-1:0] OUT_TAG,
    output logic             OUT_ZERO,
    output logic             OUT_ILLEGAL,
    output logic [CNT_W-1:0] OP_COUNT
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    dec_t             dec_p0;
    logic             vld_p1;
    logic             ill_p1;
    logic [TAG_W-1:0] tag_p1;
    logic             vld_p2;
    logic             s2_free;
    logic             s1_adv;
    logic             accept;

    shift_op_decode u_decode (
        .op      (IN_OP),
        .use_imm (IN_USE_IMM),
        .imm     (IN_IMM),
        .b_lo    (IN_B[4:0]),
        .dec     (dec_p0)
    );

    assign s2_free   = !vld_p2 || OUT_READY;
    assign s1_adv    = vld_p1 && s2_free;
    assign IN_READY  = !vld_p1 || s2_free;
    assign accept    = IN_VALID && IN_READY;
    assign OUT_VALID = vld_p2;

    // ---- stage 1: issue register, drives the shifter inputs ----
    // SH_* load only on accept so the shifter inputs stay quiet when idle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            vld_p1  <= 1'b0;
            ill_p1  <= 1'b0;
            tag_p1  <= '0;
            SH_X    <= '0;
            SH_S    <= '0;
            SH_LEFT <= 1'b0;
            SH_LOG  <= 1'b0;
        end else if (accept) begin
            vld_p1  <= 1'b1;
            ill_p1  <= dec_p0.illegal;
            tag_p1  <= IN_TAG;
            SH_X    <= IN_A;
            SH_S    <= dec_p0.amt;
            SH_LEFT <= dec_p0.left;
            SH_LOG  <= dec_p0.log;
        end else if (s1_adv) begin
            vld_p1  <= 1'b0;
        end
    end

    // ---- stage 2: result register toward writeback ----
    always_ff @(posedge CLK) begin
        if (RESET) begin
            vld_p2      <= 1'b0;
            OUT_Z       <= '0;
            OUT_TAG     <= '0;
            OUT_ZERO    <= 1'b0;
            OUT_ILLEGAL <= 1'b0;
        end else if (s1_adv) begin
            vld_p2      <= 1'b1;
            OUT_Z       <= ill_p1 ? 32'd0 : SH_Z;
            OUT_TAG     <= tag_p1;
            OUT_ZERO    <= ill_p1 || (SH_Z == 32'd0);
            OUT_ILLEGAL <= ill_p1;
        end else if (OUT_READY) begin
            vld_p2      <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            OP_COUNT <= '0;
        end else if (vld_p2 && OUT_READY) begin
            OP_COUNT <= sat_inc(OP_COUNT);
        end
    end

endmodule

// File: tb/tb_shift_issue_stage.sv
module tb_shift_issue_stage;

    localparam int TAG_W = 4;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             CLK;
    logic             RESET;
    logic             IN_VALID;
    logic             IN_READY;
    logic [1:0]       IN_OP;
    logic [31:0]      IN_A;
    logic [31:0]      IN_B;
    logic [4:0]       IN_IMM;
    logic             IN_USE_IMM;
    logic [TAG_W-1:0] IN_TAG;
    logic [31:0]      SH_X;
    logic [4:0]       SH_S;
    logic             SH_LEFT;
    logic             SH_LOG;
    logic [31:0]      SH_Z;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [31:0]      OUT_Z;
    logic [TAG_W-1:0] OUT_TAG;
    logic             OUT_ZERO;
    logic             OUT_ILLEGAL;
    logic [CNT_W-1:0] OP_COUNT;

    shift_issue_stage #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RESET(RESET),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_OP(IN_OP), .IN_A(IN_A), .IN_B(IN_B), .IN_IMM(IN_IMM),
        .IN_USE_IMM(IN_USE_IMM), .IN_TAG(IN_TAG),
        .SH_X(SH_X), .SH_S(SH_S), .SH_LEFT(SH_LEFT), .SH_LOG(SH_LOG), .SH_Z(SH_Z),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_Z(OUT_Z), .OUT_TAG(OUT_TAG), .OUT_ZERO(OUT_ZERO),
        .OUT_ILLEGAL(OUT_ILLEGAL), .OP_COUNT(OP_COUNT)
    );

    // ShiftLR stand-in connected to the SH_* ports.
    logic signed [31:0] sh_x_s;
    assign sh_x_s = SH_X;
    assign SH_Z = SH_LEFT ? (SH_X << SH_S) : (SH_LOG ? (SH_X >> SH_S) : 32'(sh_x_s >>> SH_S));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0]      z;
        logic [TAG_W-1:0] tag;
        logic             ill;
        int               acc_cyc;
    } exp_t;

    exp_t        pend[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          model_cnt = 0;
    bit          last_acc;
    logic [31:0] ex_x;
    logic [4:0]  ex_s;
    logic        ex_left;
    logic        ex_log;

    // Architectural meaning of each op, straight from the opcode table.
    function automatic logic [31:0] ref_z(input logic [1:0] op, input logic [31:0] a, input int amt);
        logic signed [31:0] sa;
        sa = a;
        case (op)
            2'b00:   return a << amt;
            2'b01:   return a >> amt;
            2'b10:   return 32'(sa >>> amt);
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check against the model, advance the model.
    task automatic step(input bit v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] imm, input bit ui, input logic [TAG_W-1:0] tag, input bit ordy);
        bit   exp_ready;
        bit   exp_ovld;
        int   amt;
        exp_t e;
        IN_VALID = v; IN_OP = op; IN_A = a; IN_B = b; IN_IMM = imm;
        IN_USE_IMM = ui; IN_TAG = tag; OUT_READY = ordy;
        #1;
        // At most two ops in flight; a full pipe frees a slot only when the result drains.
        exp_ready = (pend.size() < 2) || ordy;
        exp_ovld = 1'b0;
        if (pend.size() > 0) exp_ovld = (pend[0].acc_cyc <= cyc - 2);
        chk("in_ready", 32'(IN_READY), 32'(exp_ready));
        chk("out_valid", 32'(OUT_VALID), 32'(exp_ovld));
        chk("op_count", 32'(OP_COUNT), 32'(model_cnt));
        chk("sh_x", SH_X, ex_x);
        chk("sh_s", 32'(SH_S), 32'(ex_s));
        chk("sh_left", 32'(SH_LEFT), 32'(ex_left));
        chk("sh_log", 32'(SH_LOG), 32'(ex_log));
        if (exp_ovld) begin
            chk("out_z", OUT_Z, pend[0].z);
            chk("out_tag", 32'(OUT_TAG), 32'(pend[0].tag));
            chk("out_zero", 32'(OUT_ZERO), 32'(pend[0].z == 32'd0));
            chk("out_illegal", 32'(OUT_ILLEGAL), 32'(pend[0].ill));
        end
        if (exp_ovld && ordy) begin
            void'(pend.pop_front());
            if (model_cnt < CNT_MAX) model_cnt++;
        end
        last_acc = v && exp_ready;
        if (last_acc) begin
            amt = ui ? int'(imm) : int'(b[4:0]);
            e.z = ref_z(op, a, amt);
            e.tag = tag;
            e.ill = (op == 2'b11);
            e.acc_cyc = cyc;
            pend.push_back(e);
            ex_x = a;
            ex_s = (op == 2'b11) ? 5'd0 : 5'(amt);
            ex_left = (op == 2'b00);
            ex_log = (op != 2'b10);
        end
        @(posedge CLK);
        cyc++;
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 32'd0, 32'd0, 5'd0, 1'b0, '0, 1'b1);
    endtask

    // Reset with a valid op presented, to show reset overrides the handshake.
    task automatic do_reset();
        RESET = 1'b1; IN_VALID = 1'b1; IN_OP = 2'b00; IN_A = 32'hFFFF_FFFF;
        IN_B = 32'd3; IN_IMM = 5'd1; IN_USE_IMM = 1'b0; IN_TAG = 4'hF; OUT_READY = 1'b1;
        @(posedge CLK);
        cyc++;
        @(negedge CLK);
        RESET = 1'b0; IN_VALID = 1'b0;
        pend.delete();
        model_cnt = 0;
        ex_x = '0; ex_s = '0; ex_left = 1'b0; ex_log = 1'b0;
        #1;
        chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
        chk("rst_in_ready", 32'(IN_READY), 32'd1);
        chk("rst_op_count", 32'(OP_COUNT), 32'd0);
        chk("rst_sh_x", SH_X, 32'd0);
        chk("rst_sh_ctl", {25'd0, SH_S, SH_LEFT, SH_LOG}, 32'd0);
        chk("rst_out_z", OUT_Z, 32'd0);
        chk("rst_out_flags", {26'd0, OUT_TAG, OUT_ZERO, OUT_ILLEGAL}, 32'd0);
    endtask

    initial begin
        int n;
        RESET = 1'b1; IN_VALID = 1'b0; IN_OP = '0; IN_A = '0; IN_B = '0;
        IN_IMM = '0; IN_USE_IMM = 1'b0; IN_TAG = '0; OUT_READY = 1'b1;
        @(negedge CLK);
        do_reset();

        // SLL 1 by imm 31
        step(1'b1, 2'b00, 32'h0000_0001, 32'd0, 5'd31, 1'b1, 4'h1, 1'b1);
        idle(3);

        // SRA then SRL by register amount (low 5 bits = 4)
        step(1'b1, 2'b10, 32'h8000_0000, 32'hFFFF_FFE4, 5'd0, 1'b0, 4'h2, 1'b1);
        step(1'b1, 2'b01, 32'h8000_0000, 32'hFFFF_FFE4, 5'd0, 1'b0, 4'h3, 1'b1);
        idle(3);

        // register amount of 32 shifts by zero
        step(1'b1, 2'b00, 32'hA5A5_0001, 32'd32, 5'd7, 1'b0, 4'h4, 1'b1);
        idle(2);

        // back-pressure: 4 ops offered while the sink is stalled for 5 cycles
        n = 0;
        for (int c = 0; c < 5; c++) begin
            step(n < 4, 2'(n % 3), 32'h8000_0001 >> n, 32'd0, 5'(n + 1), 1'b1, 4'(8 + n), 1'b0);
            if (last_acc) n++;
        end
        for (int c = 0; c < 20 && n < 4; c++) begin
            step(1'b1, 2'(n % 3), 32'h8000_0001 >> n, 32'd0, 5'(n + 1), 1'b1, 4'(8 + n), 1'b1);
            if (last_acc) n++;
        end
        chk("bp_all_accepted", 32'(n), 32'd4);
        idle(3);
        chk("bp_all_drained", 32'(pend.size()), 32'd0);

        // illegal opcode
        step(1'b1, 2'b11, 32'h1234_5678, 32'd9, 5'd3, 1'b1, 4'h5, 1'b1);
        idle(3);

        // reset with both stages full
        step(1'b1, 2'b00, 32'h0000_00F0, 32'd0, 5'd2, 1'b1, 4'h6, 1'b0);
        step(1'b1, 2'b01, 32'h0000_0F00, 32'd0, 5'd3, 1'b1, 4'h7, 1'b0);
        step(1'b0, 2'b00, 32'd0, 32'd0, 5'd0, 1'b0, '0, 1'b0);
        do_reset();
        idle(4);

        // counter saturation
        for (int i = 0; i < 20; i++)
            step(1'b1, 2'(i % 3), $urandom, $urandom, 5'($urandom), 1'($urandom), 4'(i), 1'b1);
        idle(3);
        chk("op_count_saturated", 32'(OP_COUNT), 32'(CNT_MAX));

        // randomized traffic with random back-pressure
        do_reset();
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), 2'($urandom), $urandom, $urandom, 5'($urandom),
                 1'($urandom), 4'($urandom), 1'($urandom_range(0, 2) != 0));
        idle(4);
        chk("rand_all_drained", 32'(pend.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shift_issue_stage.md
Name: shift_issue_stage

Overview:
Pipeline wrapper around the combinational 32-bit shifter (ShiftLR: Z, X, S, LEFT, LOG) in the functional unit.
- Front: accepts shift ops over a valid/ready handshake, decodes the opcode into LEFT/LOG, and selects the shift amount.
- Middle: registers the operands that drive the shifter inputs.
- Back: captures the shifter result into an output register with its own valid/ready handshake toward writeback.
- Full throughput; 2-cycle latency.

Parameters:
TAG_W, 4, width of the op tag carried alongside each op.
CNT_W, 16, width of the saturating completed-op counter.

Ports:
CLK  input  1  clock; all state updates on rising edge.
RESET  input  1  reset; synchronous, active-high.
IN_VALID  input  1  upstream op valid.
IN_READY  output  1  stage can accept the op this cycle.
IN_OP  input  2  00 SLL, 01 SRL, 10 SRA, 11 illegal.
IN_A  input  32  operand to shift.
IN_B  input  32  register shift amount; only [4:0] used.
IN_IMM  input  5  immediate shift amount.
IN_USE_IMM  input  1  1 selects IN_IMM, 0 selects IN_B[4:0].
IN_TAG  input  TAG_W  op tag.
SH_X  output  32  to shifter X.
SH_S  output  5  to shifter S.
SH_LEFT  output  1  to shifter LEFT.
SH_LOG  output  1  to shifter LOG.
SH_Z  input  32  from shifter Z; combinational function of SH_* in the same cycle.
OUT_VALID  output  1  result valid.
OUT_READY  input  1  downstream accepts the result.
OUT_Z  output  32  result.
OUT_TAG  output  TAG_W  tag of the result.
OUT_ZERO  output  1  OUT_Z == 0.
OUT_ILLEGAL  output  1  op was opcode 11.
OP_COUNT  output  CNT_W  completed results, saturating.

Behaviour:
- Reset (RESET=1 at a rising edge): s1_valid=0 and s2_valid=0. SH_X, SH_S, SH_LEFT, SH_LOG, OUT_Z, OUT_TAG, OUT_ZERO, OUT_ILLEGAL and OP_COUNT all 0. RESET overrides every handshake in that cycle.
- Reset mid-operation: all in-flight ops are discarded, and nothing completes in the reset cycle.
- Stage 1 (issue register): on accept (IN_VALID && IN_READY) it captures A, the selected amount, the decoded LEFT/LOG, the tag, and an illegal flag. SH_* are driven directly from this register.
- Opcode decode:
  - SLL: LEFT=1, LOG=1.
  - SRL: LEFT=0, LOG=1.
  - SRA: LEFT=0, LOG=0.
  - Opcode 11: LEFT=0, LOG=1, S=0, illegal=1.
- Shift amount: IN_IMM when IN_USE_IMM=1, otherwise IN_B[4:0]. IN_B[31:5] is ignored, so 32 shifts by 0.
- Stage 2 (result register): captures SH_Z, the stage-1 tag and the illegal flag when stage 1 advances.
  - OUT_Z = SH_Z, forced to 0 when illegal.
  - OUT_ZERO = (captured OUT_Z == 0); it is registered.
- Advance rules:
  - s2_free = !s2_valid || OUT_READY.
  - s1_adv = s1_valid && s2_free.
  - IN_READY = !s1_valid || s2_free (combinational from OUT_READY).
- Latency: accept at edge N gives OUT_VALID=1 after edge N+1. With OUT_READY held at 1, one result completes per cycle.
- Back-pressure: while OUT_VALID && !OUT_READY, OUT_* hold stable. Stage 1 also holds, so SH_* stay stable and SH_Z stays stable.
- Simultaneous events:
  - A stage-2 drain, a stage-1 advance and a new accept in the same cycle all occur; no bubble.
  - When stage 1 empties with no new accept, SH_* keep their last values, so the shifter inputs do not toggle.
- OP_COUNT: increments on OUT_VALID && OUT_READY, including illegal ops. It saturates at all-ones.
- No combinational path from IN_* to OUT_*.

Decomposition:
- Shared package holds:
  - Opcode constants OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b10, OP_ILL=2'b11.
  - Decode localparams for the LEFT/LOG pairs.
- One natural sub-module: shift_op_decode. It is combinational: IN_OP, IN_USE_IMM, IN_IMM, IN_B[4:0] in; LEFT, LOG, S, illegal out.
- The shifter itself is not instantiated inside; the bench and the top level connect ShiftLR to the SH_* ports.

Test Plan:
1. SLL: A=0x00000001, IMM=31, USE_IMM=1, OUT_READY=1 -> OUT_Z=0x80000000 two cycles after accept, OUT_ZERO=0.
2. SRA then SRL: A=0x80000000, B=0xFFFFFFE4 (amount 4), USE_IMM=0 -> OUT_Z=0xF8000000, then 0x08000000 on consecutive cycles. Tags are preserved in order.
3. Back-pressure: 4 back-to-back ops with OUT_READY=0 for 5 cycles.
   - IN_READY drops after 2 accepts.
   - OUT_* and SH_* are stable throughout.
   - After release, all 4 results arrive in order with no loss or duplication.
4. Illegal: OP=11, A=0x12345678 -> OUT_ILLEGAL=1, OUT_Z=0, OUT_ZERO=1, OP_COUNT increments.
5. Reset mid-flight: assert RESET with both stages valid -> next cycle OUT_VALID=0, IN_READY=1, OP_COUNT=0, SH_*=0, and no stale result appears afterward.
6. Counter saturation: with CNT_W=4, complete 20 ops -> OP_COUNT=15.
